// File: rtl/seg_pkg.sv
// Shared segment-pattern constants, FSM states and the pattern-to-code decode
// used by the multiplexed 7-segment readback decoder.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_B     = SEG_BLANK;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b0000001;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;

  localparam logic [3:0] CODE_BLANK = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

  // Returns {illegal, code}; unknown patterns report blank with illegal set.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      SEG_0:   r = {1'b0, 4'h0};
      SEG_1:   r = {1'b0, 4'h1};
      SEG_2:   r = {1'b0, 4'h2};
      SEG_3:   r = {1'b0, 4'h3};
      SEG_4:   r = {1'b0, 4'h4};
      SEG_5:   r = {1'b0, 4'h5};
      SEG_6:   r = {1'b0, 4'h6};
      SEG_7:   r = {1'b0, 4'h7};
      SEG_8:   r = {1'b0, 4'h8};
      SEG_9:   r = {1'b0, 4'h9};
      SEG_A:   r = {1'b0, 4'hA};
      SEG_B:   r = {1'b0, CODE_BLANK};
      SEG_C:   r = {1'b0, 4'hC};
      SEG_E:   r = {1'b0, 4'hE};
      SEG_F:   r = {1'b0, 4'hF};
      default: r = {1'b1, CODE_BLANK};
    endcase
    // D is drawn identically to 0, so the shared pattern always reads back as 0.
    if (pat == SEG_D) r = {1'b0, 4'h0};
    return r;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to 4-bit code decoder with illegal-pattern flag.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] code,
  output logic       illegal
);

  assign {illegal, code} = seg_decode(pat);

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs per-digit codes from a multiplexed active-low 7-segment bus.
// Optional SEG_GLITCH_CNT_EN adds glitch_cnt, a saturating count of stability restarts.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    bus_err
`ifdef SEG_GLITCH_CNT_EN
  ,
  output logic [7:0]              glitch_cnt
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [6:0]            seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] an_s1, an_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= SEG_BLANK;
      seg_s2 <= SEG_BLANK;
      an_s1  <= '1;
      an_s2  <= '1;
    end else begin
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      an_s1  <= an_n;
      an_s2  <= an_s1;
    end
  end

  logic [3:0]       act_n;
  logic [IDX_W-1:0] act_idx;
  logic             one_act, multi_act;

  always_comb begin
    act_n   = 4'd0;
    act_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!an_s2[i]) begin
        act_n   = act_n + 4'd1;
        act_idx = IDX_W'(i);
      end
    end
  end

  assign one_act   = (act_n == 4'd1);
  assign multi_act = (act_n > 4'd1);

  state_t           state;
  logic [IDX_W-1:0] cur_idx;
  logic [6:0]       ref_pat;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             cap_req, restart, glitch_evt;

  // A new single anode (from IDLE or a different digit) starts a fresh stability run.
  assign restart    = one_act && (state == IDLE || act_idx != cur_idx);
  assign glitch_evt = one_act && !restart && state == COUNT && seg_s2 != ref_pat;
  assign cnt_inc    = (cnt >= CNT_DONE) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_idx <= '0;
      ref_pat <= SEG_BLANK;
      cnt     <= '0;
      cap_req <= 1'b0;
    end else begin
      cap_req <= 1'b0;
      if (!one_act) begin
        state <= IDLE;
      end else if (restart) begin
        cur_idx <= act_idx;
        ref_pat <= seg_s2;
        cnt     <= CNT_ONE;
        if (CNT_ONE == CNT_DONE) begin
          cap_req <= 1'b1;
          state   <= HOLD;
        end else begin
          state <= COUNT;
        end
      end else if (glitch_evt) begin
        ref_pat <= seg_s2;
        cnt     <= CNT_ONE;
      end else if (state == COUNT) begin
        cnt <= cnt_inc;
        if (cnt_inc == CNT_DONE) begin
          cap_req <= 1'b1;
          state   <= HOLD;
        end
      end
    end
  end

`ifdef SEG_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 8'd0;
    end else if (glitch_evt && glitch_cnt != 8'hFF) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

  logic [3:0] dec_code;
  logic       dec_ill;

  seg_pattern_decode u_decode (
    .pat     (ref_pat),
    .code    (dec_code),
    .illegal (dec_ill)
  );

  logic [NUM_DIGITS-1:0] mask, cap_bit;

  assign cap_bit = cap_req ? (NUM_DIGITS'(1) << cur_idx) : '0;

  // The full mask is held for one cycle, then cleared while frame_valid pulses;
  // a capture landing in that clearing cycle keeps its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= {NUM_DIGITS{CODE_BLANK}};
      digit_err   <= '0;
      mask        <= '0;
      frame_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      bus_err     <= multi_act;
      frame_valid <= (mask == '1);
      if (mask == '1) mask <= cap_bit;
      else            mask <= mask | cap_bit;
      if (cap_req) begin
        digits[{cur_idx, 2'b00} +: 4] <= dec_code;
        digit_err[cur_idx]            <= dec_ill;
      end
    end
  end

endmodule
